// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding bus fetcher with redirect and stall.
// Ports: clk/rstn, jump_flag_i/jump_addr_i redirect, hold_flag_i stall bus,
//        ibus_* request/grant/response channel, inst_o/inst_addr_o/inst_valid_o to if2id.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam logic [31:0] INST_NOP = 32'h0000_0001;
    localparam logic [2:0]  HOLD_PC  = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        kill;
    logic        buf_valid;
    logic [31:0] buf_inst;
    logic [31:0] buf_addr;

    logic        stall;
    logic        keep;
    logic [31:0] pc_next;

    assign stall   = (hold_flag_i >= HOLD_PC);
    // A response is kept only if it belongs to a live (not redirected) fetch.
    assign keep    = (state == WAIT) && ibus_rvalid_i && !kill;
    assign pc_next = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            buf_valid    <= 1'b0;
            buf_inst     <= 32'h0;
            buf_addr     <= 32'h0;
            ibus_req_o   <= 1'b0;
            ibus_addr_o  <= RESET_PC;
            inst_o       <= INST_NOP;
            inst_addr_o  <= 32'h0;
            inst_valid_o <= 1'b0;
        end else if (jump_flag_i) begin
            pc           <= jump_addr_i & 32'hFFFF_FFFC;
            buf_valid    <= 1'b0;
            inst_o       <= INST_NOP;
            inst_valid_o <= 1'b0;
            // The bus transaction in flight must still complete; mark it dead.
            case (state)
                REQ: begin
                    kill <= 1'b1;
                    if (ibus_gnt_i) begin
                        state      <= WAIT;
                        ibus_req_o <= 1'b0;
                    end
                end
                WAIT: begin
                    if (ibus_rvalid_i) begin
                        state <= IDLE;
                        kill  <= 1'b0;
                    end else begin
                        kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (!stall && !buf_valid) begin
                        state       <= REQ;
                        ibus_req_o  <= 1'b1;
                        ibus_addr_o <= pc;
                    end
                end
                REQ: begin
                    if (ibus_gnt_i) begin
                        state      <= WAIT;
                        ibus_req_o <= 1'b0;
                    end
                end
                WAIT: begin
                    if (ibus_rvalid_i) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            pc <= pc_next;
                            // Buffer is always empty while waiting, so only
                            // the stall decides whether to issue straight on.
                            if (!stall) begin
                                state       <= REQ;
                                ibus_req_o  <= 1'b1;
                                ibus_addr_o <= pc_next;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (keep && !stall) begin
                inst_o       <= ibus_rdata_i;
                inst_addr_o  <= ibus_addr_o;
                inst_valid_o <= 1'b1;
            end else if (keep) begin
                buf_inst  <= ibus_rdata_i;
                buf_addr  <= ibus_addr_o;
                buf_valid <= 1'b1;
            end else if (!stall) begin
                if (buf_valid) begin
                    inst_o       <= buf_inst;
                    inst_addr_o  <= buf_addr;
                    inst_valid_o <= 1'b1;
                    buf_valid    <= 1'b0;
                end else begin
                    inst_o       <= INST_NOP;
                    inst_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: randomized bus slave and stalls/jumps against
// a transaction-level reference model of fetch order and output contents.
module tb_ifu_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0001;
    localparam logic [31:0] DEAD = 32'h0000_DEAD;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic [2:0]  hold_flag = 3'd0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk          (clk),
        .rstn         (rstn),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .hold_flag_i  (hold_flag),
        .ibus_req_o   (ibus_req),
        .ibus_addr_o  (ibus_addr),
        .ibus_gnt_i   (gnt),
        .ibus_rvalid_i(rvalid),
        .ibus_rdata_i (rdata),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_valid_o (inst_valid)
    );

    int checks = 0;
    int errors = 0;

    // reference model: next fetch address, undelivered responses, outputs
    logic [31:0] m_pc, m_inst, m_addr;
    logic        m_valid;
    logic [31:0] q[$];

    // bus slave
    bit          pending, pend_kill, req_kill;
    logic [31:0] pend_addr;
    int          gnt_cnt, gnt_need, rv_cnt, rv_need;
    int          gnt_lo = 0, gnt_hi = 0, rv_lo = 0, rv_hi = 0;
    int          n_grant, n_deliv;
    logic [31:0] last_grant, prev_live_grant;
    bit          saw_wrap;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        return {a[15:0] ^ 16'h5a5a, a[31:16]};
    endfunction

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_inst = NOP; m_addr = 32'h0; m_valid = 1'b0;
        q.delete();
        pending = 0; pend_kill = 0; req_kill = 0; pend_addr = 32'h0;
        gnt_cnt = 0; rv_cnt = 0;
        gnt_need = rnd(gnt_lo, gnt_hi);
        rv_need = rnd(rv_lo, rv_hi);
        prev_live_grant = 32'h1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        jump_flag = 1'b0; hold_flag = 3'd0;
        @(posedge clk); #1;
        chk("rst_req", ibus_req, 1'b0);
        chk("rst_addr", ibus_addr, 32'h0);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_addr", inst_addr, 32'h0);
        chk("rst_valid", inst_valid, 1'b0);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic step(input bit jmp, input logic [31:0] ja,
                        input logic [2:0] hold, input bit stray);
        bit          req_pre, g, rv, stall, rsp_ok;
        logic [31:0] addr_pre;
        int          qbefore;
        req_pre = ibus_req;
        addr_pre = ibus_addr;
        stall = (hold != 3'd0);
        qbefore = q.size();
        g = req_pre && !pending && (gnt_cnt >= gnt_need);
        rv = pending && (rv_cnt >= rv_need);
        gnt = g;
        rvalid = rv || stray;
        rdata = (rv && !pend_kill) ? mem(pend_addr) : DEAD;
        hold_flag = hold;
        jump_flag = jmp;
        jump_addr = ja;
        @(posedge clk); #1;

        rsp_ok = rv && !pend_kill && !jmp;
        if (jmp) begin
            if (req_pre) req_kill = 1;
            if (pending && !rv) pend_kill = 1;
            m_pc = ja & 32'hFFFF_FFFC;
        end
        if (rsp_ok) q.push_back(pend_addr);
        if (rv) pending = 0;
        else if (pending) rv_cnt++;

        if (g) begin
            n_grant++;
            last_grant = addr_pre;
            pending = 1;
            pend_addr = addr_pre;
            pend_kill = req_kill;
            req_kill = 0;
            rv_cnt = 0;
            rv_need = rnd(rv_lo, rv_hi);
            gnt_cnt = 0;
            gnt_need = rnd(gnt_lo, gnt_hi);
            if (!pend_kill) begin
                chk("grant_addr", addr_pre, m_pc);
                if (prev_live_grant == 32'hFFFF_FFFC && addr_pre == 32'h0)
                    saw_wrap = 1;
                prev_live_grant = addr_pre;
                m_pc = m_pc + 32'd4;
            end
        end else if (req_pre) begin
            gnt_cnt++;
            chk("req_held", ibus_req, 1'b1);
            chk("addr_held", ibus_addr, addr_pre);
        end

        if (jmp) begin
            q.delete();
            m_inst = NOP;
            m_valid = 1'b0;
        end else if (!stall) begin
            if (q.size() > 0) begin
                m_addr = q.pop_front();
                m_inst = mem(m_addr);
                m_valid = 1'b1;
                n_deliv++;
            end else begin
                m_inst = NOP;
                m_valid = 1'b0;
            end
        end

        chk("inst", inst, m_inst);
        chk("inst_addr", inst_addr, m_addr);
        chk("inst_valid", inst_valid, m_valid);
        chk("one_outstanding", pending && ibus_req, 1'b0);
        if (!req_pre && ibus_req)
            chk("issue_legal", stall || jmp || qbefore != 0, 1'b0);
    endtask

    function automatic logic [2:0] rhold();
        return ($urandom_range(9) < 3) ? 3'($urandom_range(7, 1)) : 3'd0;
    endfunction

    initial begin
        int          g0;
        logic [31:0] a37;
        n_grant = 0; n_deliv = 0; saw_wrap = 0; last_grant = 32'h0;
        do_reset();

        // first fetch with immediate grant; stray rvalid right after release
        step(0, 32'h0, 3'd0, 1);
        chk("r034_req", ibus_req, 1'b1);
        chk("r034_addr0", ibus_addr, 32'h0);
        step(0, 32'h0, 3'd0, 0);
        step(0, 32'h0, 3'd0, 0);
        chk("r034_inst", inst, 32'h0000_0093);
        chk("r034_iaddr", inst_addr, 32'h0);
        chk("r034_valid", inst_valid, 1'b1);
        chk("r034_addr4", ibus_addr, 32'h4);

        // grant withheld for three cycles
        gnt_lo = 3; gnt_hi = 3; gnt_need = 3;
        rv_lo = 4; rv_hi = 4;
        g0 = n_grant;
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 3'd0, 0);
            chk("r035_req", ibus_req, 1'b1);
            chk("r035_addr", ibus_addr, 32'h4);
        end
        step(0, 32'h0, 3'd0, 0);
        chk("r035_single", n_grant - g0, 1);

        // redirect while waiting on address 8
        for (int i = 0; i < 30; i++) begin
            if (pending && pend_addr == 32'h8) break;
            step(0, 32'h0, 3'd0, 0);
        end
        chk("r036_wait8", pending && pend_addr == 32'h8, 1'b1);
        step(1, 32'h100, 3'd0, 0);
        g0 = n_grant;
        for (int i = 0; i < 30; i++) begin
            if (n_grant > g0) break;
            step(0, 32'h0, 3'd0, 0);
        end
        chk("r036_next", last_grant, 32'h100);

        // stall across a response, then release from the skid buffer
        gnt_lo = 0; gnt_hi = 0; rv_lo = 2; rv_hi = 2;
        for (int i = 0; i < 20; i++) begin
            if (pending && !pend_kill) break;
            step(0, 32'h0, 3'd0, 0);
        end
        a37 = pend_addr;
        for (int i = 0; i < 8; i++) step(0, 32'h0, 3'd2, 0);
        chk("r037_frozen", inst === mem(a37), 1'b0);
        step(0, 32'h0, 3'd0, 0);
        chk("r037_rel", inst, mem(a37));
        chk("r037_rel_addr", inst_addr, a37);

        // wrap at the top of the address space (low jump bits ignored)
        gnt_lo = 0; gnt_hi = 3; rv_lo = 0; rv_hi = 3;
        step(1, 32'hFFFF_FFFF, 3'd0, 0);
        for (int i = 0; i < 40; i++) step(0, 32'h0, 3'd0, 0);
        chk("r038_wrap", saw_wrap, 1'b1);

        // randomized traffic with stalls and redirects
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3)
                step(1, $urandom, rhold(), 0);
            else
                step(0, 32'h0, rhold(), 0);
        end
        chk("liveness", n_deliv > 200, 1'b1);

        // reset while a request is being presented
        for (int i = 0; i < 20; i++) begin
            if (ibus_req) break;
            step(0, 32'h0, 3'd0, 0);
        end
        chk("r039_in_req", ibus_req, 1'b1);
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 32'h0, 3'd0, 0);
        chk("r039_restart", n_deliv > 200, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single core clock; all state updates on rising edge.
REQ-003 rstn  input  1  synchronous active-low reset.
REQ-004 jump_flag_i  input  1  redirect request from execute stage.
REQ-005 jump_addr_i  input  32  redirect target, valid with jump_flag_i.
REQ-006 hold_flag_i  input  3  `Hold_Flag_Bus; fetch stalls when value >= `Hold_Pc (1).
REQ-007 ibus_req_o  output  1  instruction bus request.
REQ-008 ibus_addr_o  output  32  request address, word aligned.
REQ-009 ibus_gnt_i  input  1  request accepted this cycle.
REQ-010 ibus_rvalid_i  input  1  read data valid.
REQ-011 ibus_rdata_i  input  32  read data.
REQ-012 inst_o  output  32  fetched instruction to if2id.
REQ-013 inst_addr_o  output  32  address of inst_o.
REQ-014 inst_valid_o  output  1  inst_o holds a real fetched instruction.

Function
REQ-015 FSM states IDLE, REQ, WAIT; at most one outstanding bus transaction.
REQ-016 IDLE: when not stalled and skid buffer empty, next cycle enter REQ with ibus_addr_o=pc; otherwise remain IDLE.
REQ-017 REQ: ibus_req_o=1; ibus_addr_o stays stable until ibus_gnt_i=1; on gnt enter WAIT.
REQ-018 WAIT: ibus_req_o=0; on ibus_rvalid_i=1: pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), go to REQ if not stalled and buffer will be empty, else IDLE.
REQ-019 Response capture, not stalled: inst_o<=ibus_rdata_i, inst_addr_o<=transaction address, inst_valid_o<=1, one cycle after rvalid.
REQ-020 Response capture, stalled: data/address go to a one-entry skid buffer; outputs hold previous values.
REQ-021 Stalled cycle with no new data: inst_o, inst_addr_o, inst_valid_o hold.
REQ-022 Not stalled, no new data, buffer empty: inst_o<=`INST_NOP (32'h0000_0001), inst_valid_o<=0, inst_addr_o holds.
REQ-023 Stall release with buffer full: buffer moves to outputs on the first unstalled cycle, buffer clears, and issue resumes the next cycle.
REQ-024 Jump, any state: pc<=jump_addr_i; skid buffer cleared; outputs <=`INST_NOP/valid 0 next cycle.
REQ-025 Jump in REQ (before gnt) or WAIT: set kill flag; the in-flight response is consumed and discarded, pc unchanged by it; address in REQ is not altered.
REQ-026 After a killed response: FSM returns to IDLE, and the next request uses the redirected pc.
REQ-027 Jump in IDLE: no kill; next request uses jump_addr_i.
REQ-028 Jump coincident with rvalid: response discarded; jump wins.
REQ-029 Jump while stalled: redirect accepted; no new request until the stall clears.
REQ-030 Stall never withdraws an asserted ibus_req_o; an outstanding request completes.
REQ-031 jump_addr_i[1:0] ignored; pc[1:0] forced to 0.

Reset
REQ-032 rstn=0 sampled at clk edge: pc=RESET_PC, state=IDLE, kill=0, buffer empty, ibus_req_o=0, ibus_addr_o=RESET_PC, inst_o=`INST_NOP, inst_addr_o=0, inst_valid_o=0.
REQ-033 Reset mid-transaction abandons it; any rvalid within 1 cycle after reset release without an issued request is ignored.

Verification
REQ-034 Reset release, gnt immediate, rvalid 1 cycle later with data 0x0000_0093 -> ibus_addr_o=0x0, then 0x4; inst_o=0x93, inst_addr_o=0x0, valid=1.
REQ-035 gnt withheld 3 cycles -> ibus_req_o=1 and ibus_addr_o constant all 3 cycles, with a single transaction counted.
REQ-036 Jump to 0x100 while in WAIT for addr 0x8, rvalid data 0xDEAD -> 0xDEAD never appears on inst_o; next request addr=0x100.
REQ-037 hold_flag_i=`Hold_If asserted during WAIT, rvalid arrives -> outputs frozen; on release inst_o=buffered data next cycle; no new request while buffer is full.
REQ-038 pc=0xFFFF_FFFC response -> next ibus_addr_o=0x0000_0000.
REQ-039 rstn=0 asserted while in REQ -> next cycle ibus_req_o=0, inst_o=0x1, pc=RESET_PC.
